// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one 16-bit word access at a time,
// with configurable read strobe and write pulse widths and byte enables.
module sram_ctrl #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  // Counter reload values: the counter counts down to zero, so N cycles load N-1.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        dq_oe;
  logic        accept;
  logic        rd_done;
  logic        wr_done;

  // Gating with rst_n keeps ready low for the whole time reset is held.
  assign req_ready = rst_n && (state == IDLE);
  assign sram_dq   = dq_oe ? wdata_q : 16'hzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    dq_oe     = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_we ? WR_SETUP : RD;
          cnt_nxt   = req_we ? 4'd0 : RD_LOAD;
        end
      end
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = ~be_q[1];
        sram_lb_n = ~be_q[0];
        if (cnt == 4'd0) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_SETUP: begin
        sram_ce_n = 1'b0;
        sram_ub_n = ~be_q[1];
        sram_lb_n = ~be_q[0];
        dq_oe     = 1'b1;
        state_nxt = WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      WR_PULSE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_ub_n = ~be_q[1];
        sram_lb_n = ~be_q[0];
        dq_oe     = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = WR_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        // Data stays on the bus one cycle past the we_n rising edge for hold time.
        sram_ce_n = 1'b0;
        sram_ub_n = ~be_q[1];
        sram_lb_n = ~be_q[0];
        dq_oe     = 1'b1;
        wr_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= 18'h0;
      wdata_q   <= 16'h0;
      be_q      <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0;
    end else begin
      rsp_valid <= rd_done || wr_done;
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
        be_q      <= req_be;
      end
      // Disabled byte lanes are not driven by the SRAM, so they read back as zero.
      if (rd_done) begin
        rsp_rdata <= {be_q[1] ? sram_dq[15:8] : 8'h00,
                      be_q[0] ? sram_dq[7:0]  : 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: behavioural SRAM on the pins plus a word-level
// reference memory; a second instance checks non-default wait parameters.
module tb_sram_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic        r2_valid = 1'b0;
  logic        r2_we = 1'b0;
  logic [17:0] r2_addr = '0;
  logic [15:0] r2_wdata = '0;
  logic [1:0]  r2_be = '0;
  logic        r2_ready, r2_rsp_valid;
  logic [15:0] r2_rdata;
  logic [17:0] r2_sram_addr;
  wire  [15:0] r2_dq;
  logic        r2_ce_n, r2_oe_n, r2_we_n, r2_ub_n, r2_lb_n;

  int checks = 0;
  int passes = 0;
  int viol = 0;

  int   last_lat, last_oe_low, last_we_low;
  logic last_ctrl_ok, last_idle_ok;

  always #5 clk = ~clk;

  sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr),
    .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_ctrl #(.READ_WAIT(5), .WRITE_WAIT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_we(r2_we), .req_addr(r2_addr), .req_wdata(r2_wdata), .req_be(r2_be),
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata), .sram_addr(r2_sram_addr),
    .sram_dq(r2_dq), .sram_ce_n(r2_ce_n), .sram_oe_n(r2_oe_n),
    .sram_we_n(r2_we_n), .sram_ub_n(r2_ub_n), .sram_lb_n(r2_lb_n)
  );

  // Power-up contents shared by the pin-level SRAM and the reference memory.
  function automatic logic [15:0] init_word(input logic [17:0] a);
    return a[15:0] ^ 16'h6B2D ^ {14'h0, a[17:16]};
  endfunction

  // Pin-level SRAM: writes on clock edges while ce_n/we_n are low; when the
  // chip is deselected the bench parks 16'h0000 on the bus as a drive probe.
  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] model_dout = 16'h0;
  logic [15:0] wr_tmp;

  function automatic logic [15:0] sram_get(input logic [17:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
  endfunction

  assign sram_dq = (sram_ce_n != 1'b0) ? 16'h0000 :
                   ((sram_oe_n == 1'b0 && sram_we_n == 1'b1) ? model_dout : 16'hzzzz);
  assign r2_dq   = (r2_ce_n == 1'b0 && r2_oe_n == 1'b0) ? 16'h5A5A : 16'hzzzz;

  always @(negedge clk) model_dout <= sram_get(sram_addr);

  always @(posedge clk) begin
    if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
      wr_tmp = sram_get(sram_addr);
      if (sram_ub_n === 1'b0) wr_tmp[15:8] = sram_dq[15:8];
      if (sram_lb_n === 1'b0) wr_tmp[7:0]  = sram_dq[7:0];
      sram_mem[sram_addr] = wr_tmp;
    end
  end

  // Bus protocol violations are tallied here and judged by the tests.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_oe_n && !sram_we_n) viol++;
      if (!sram_oe_n && sram_dq !== model_dout) viol++;
      if (sram_ce_n && sram_dq !== 16'h0000) viol++;
      if (sram_ce_n && (!sram_oe_n || !sram_we_n)) viol++;
      if (!r2_oe_n && !r2_we_n) viol++;
      if (!r2_oe_n && r2_dq !== 16'h5A5A) viol++;
    end
  end

  // Word-level reference: what a reader should see after completed writes.
  logic [15:0] ref_mem [logic [17:0]];

  function automatic logic [15:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic void ref_write(input logic [17:0] a, input logic [15:0] d,
                                    input logic [1:0] be);
    logic [15:0] w;
    w = ref_get(a);
    if (be[1]) w[15:8] = d[15:8];
    if (be[0]) w[7:0]  = d[7:0];
    ref_mem[a] = w;
  endfunction

  function automatic logic [15:0] ref_read(input logic [17:0] a, input logic [1:0] be);
    logic [15:0] w;
    w = ref_get(a);
    return {be[1] ? w[15:8] : 8'h00, be[0] ? w[7:0] : 8'h00};
  endfunction

  // Presents one request from an idle negedge and follows it to its response.
  task automatic issue(input bit we, input logic [17:0] addr, input logic [15:0] wd,
                       input logic [1:0] be);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 18'($urandom);
    req_wdata = 16'($urandom); req_be = 2'($urandom);
    last_lat = 1; last_oe_low = 0; last_we_low = 0; last_ctrl_ok = 1'b1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && last_lat < 40) begin
      if (sram_oe_n === 1'b0) last_oe_low++;
      if (sram_we_n === 1'b0) last_we_low++;
      if (sram_ce_n !== 1'b0 || sram_addr !== addr ||
          sram_ub_n !== ~be[1] || sram_lb_n !== ~be[0]) last_ctrl_ok = 1'b0;
      if (we && sram_dq !== wd) last_ctrl_ok = 1'b0;
      @(negedge clk);
      last_lat++;
    end
    last_idle_ok = (sram_ce_n === 1'b1 && sram_oe_n === 1'b1 && sram_we_n === 1'b1 &&
                    sram_dq === 16'h0000 && req_ready === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== 16'h0) $display("[TB] FAIL rst_rdata: got %h want 0000", rsp_rdata); else passes++;
    checks++; if (sram_addr !== 18'h0) $display("[TB] FAIL rst_addr: got %h want 00000", sram_addr); else passes++;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111)
      $display("[TB] FAIL rst_ctrl: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    else passes++;
    checks++; if (sram_dq !== 16'h0000) $display("[TB] FAIL rst_dq_released: got %h want 0000", sram_dq); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); else passes++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(1'b1, 18'h00010, 16'hA5C3, 2'b11);
    ref_write(18'h00010, 16'hA5C3, 2'b11);
    checks++; if (last_lat !== WW + 3) $display("[TB] FAIL wr_latency: got %0d want %0d", last_lat, WW + 3); else passes++;
    checks++; if (last_we_low !== WW) $display("[TB] FAIL wr_we_low: got %0d want %0d", last_we_low, WW); else passes++;
    checks++; if (last_oe_low !== 0) $display("[TB] FAIL wr_oe_low: got %0d want 0", last_oe_low); else passes++;
    checks++; if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL wr_ctrl_stable: got %b want 1", last_ctrl_ok); else passes++;
    checks++; if (last_idle_ok !== 1'b1) $display("[TB] FAIL wr_idle_outputs: got %b want 1", last_idle_ok); else passes++;
    issue(1'b0, 18'h00010, 16'h0, 2'b11);
    checks++; if (last_lat !== RW + 1) $display("[TB] FAIL rd_latency: got %0d want %0d", last_lat, RW + 1); else passes++;
    checks++; if (last_oe_low !== RW) $display("[TB] FAIL rd_oe_low: got %0d want %0d", last_oe_low, RW); else passes++;
    checks++; if (rsp_rdata !== 16'hA5C3) $display("[TB] FAIL rd_data: got %h want a5c3", rsp_rdata); else passes++;
    checks++; if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL rd_ctrl: got %b want 1", last_ctrl_ok); else passes++;
  endtask

  task automatic test_byte_enables();
    issue(1'b1, 18'h3FFFF, 16'h1234, 2'b11); ref_write(18'h3FFFF, 16'h1234, 2'b11);
    issue(1'b1, 18'h3FFFF, 16'hFFEE, 2'b10); ref_write(18'h3FFFF, 16'hFFEE, 2'b10);
    checks++; if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL be10_ctrl: got %b want 1", last_ctrl_ok); else passes++;
    issue(1'b0, 18'h3FFFF, 16'h0, 2'b11);
    checks++; if (rsp_rdata !== 16'hFF34) $display("[TB] FAIL be_merge: got %h want ff34", rsp_rdata); else passes++;
    issue(1'b1, 18'h3FFFF, 16'h0000, 2'b00); ref_write(18'h3FFFF, 16'h0000, 2'b00);
    checks++; if (last_lat !== WW + 3) $display("[TB] FAIL be00_latency: got %0d want %0d", last_lat, WW + 3); else passes++;
    checks++; if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL be00_ctrl: got %b want 1", last_ctrl_ok); else passes++;
    issue(1'b0, 18'h3FFFF, 16'h0, 2'b11);
    checks++; if (rsp_rdata !== 16'hFF34) $display("[TB] FAIL be00_unchanged: got %h want ff34", rsp_rdata); else passes++;
    issue(1'b1, 18'h00042, 16'hBEEF, 2'b11); ref_write(18'h00042, 16'hBEEF, 2'b11);
    issue(1'b0, 18'h00042, 16'h0, 2'b01);
    checks++; if (rsp_rdata !== 16'h00EF) $display("[TB] FAIL be01_read: got %h want 00ef", rsp_rdata); else passes++;
    checks++; if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL be01_ub_high: got %b want 1", last_ctrl_ok); else passes++;
  endtask

  task automatic test_ignored();
    int          lat;
    logic [17:0] b_addr;
    b_addr = 18'h01234;
    req_we = 1'b0; req_addr = 18'h00010; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = b_addr; req_wdata = ~ref_get(b_addr); req_be = 2'b11;
    lat = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    checks++; if (lat !== RW + 1) $display("[TB] FAIL ign_latency: got %0d want %0d", lat, RW + 1); else passes++;
    checks++;
    if (rsp_rdata !== ref_read(18'h00010, 2'b11))
      $display("[TB] FAIL ign_rdata: got %h want %h", rsp_rdata, ref_read(18'h00010, 2'b11));
    else passes++;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL ign_not_queued: got %b want 1", req_ready); else passes++;
    issue(1'b0, b_addr, 16'h0, 2'b11);
    checks++;
    if (rsp_rdata !== ref_read(b_addr, 2'b11))
      $display("[TB] FAIL ign_mem_unchanged: got %h want %h", rsp_rdata, ref_read(b_addr, 2'b11));
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit          op_we   [3];
    logic [17:0] op_addr [3];
    logic [15:0] op_wd   [3];
    logic [1:0]  op_be   [3];
    int          acc     [3];
    int          nxt, done, cyc, viol0, exp_lat;
    op_we   = '{1'b0, 1'b1, 1'b0};
    op_addr = '{18'h00100, 18'h00200, 18'h00200};
    op_wd   = '{16'h0, 16'($urandom), 16'h0};
    op_be   = '{2'b11, 2'b01, 2'b11};
    nxt = 0; done = 0; cyc = 0; viol0 = viol;
    while (done < 3 && cyc < 60) begin
      if (rsp_valid === 1'b1 && nxt > done) begin
        exp_lat = op_we[done] ? WW + 3 : RW + 1;
        checks++;
        if (cyc - acc[done] !== exp_lat)
          $display("[TB] FAIL b2b_latency%0d: got %0d want %0d", done, cyc - acc[done], exp_lat);
        else passes++;
        if (op_we[done]) ref_write(op_addr[done], op_wd[done], op_be[done]);
        else begin
          checks++;
          if (rsp_rdata !== ref_read(op_addr[done], op_be[done]))
            $display("[TB] FAIL b2b_rdata%0d: got %h want %h", done, rsp_rdata, ref_read(op_addr[done], op_be[done]));
          else passes++;
        end
        done++;
      end
      if (req_ready === 1'b1 && nxt < 3) begin
        if (nxt > 0) begin
          checks++;
          if (rsp_valid !== 1'b1) $display("[TB] FAIL b2b_accept_in_rsp%0d: got %b want 1", nxt, rsp_valid);
          else passes++;
        end
        req_we = op_we[nxt]; req_addr = op_addr[nxt]; req_wdata = op_wd[nxt];
        req_be = op_be[nxt]; req_valid = 1'b1;
        acc[nxt] = cyc;
        nxt++;
      end
      if (done < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 1'b0;
    checks++; if (done !== 3) $display("[TB] FAIL b2b_completed: got %0d want 3", done); else passes++;
    checks++; if (viol !== viol0) $display("[TB] FAIL b2b_protocol: got %0d violations want 0", viol - viol0); else passes++;
  endtask

  task automatic test_random();
    bit          we;
    logic [17:0] a;
    logic [15:0] d, prev, exp;
    logic [1:0]  be;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 18'h00000;
        1:       a = 18'h3FFFF;
        2:       a = 18'h00010 + 18'($urandom_range(0, 3));
        default: a = 18'($urandom);
      endcase
      d = 16'($urandom); be = 2'($urandom);
      prev = rsp_rdata;
      exp  = ref_read(a, be);
      issue(we, a, d, be);
      checks++;
      if (last_lat !== (we ? WW + 3 : RW + 1))
        $display("[TB] FAIL rand_latency%0d: got %0d want %0d", i, last_lat, we ? WW + 3 : RW + 1);
      else passes++;
      if (we) begin
        ref_write(a, d, be);
        checks++;
        if (rsp_rdata !== prev) $display("[TB] FAIL rand_rdata_hold%0d: got %h want %h", i, rsp_rdata, prev);
        else passes++;
      end else begin
        checks++;
        if (rsp_rdata !== exp) $display("[TB] FAIL rand_rdata%0d: got %h want %h", i, rsp_rdata, exp);
        else passes++;
      end
      checks++;
      if (last_ctrl_ok !== 1'b1) $display("[TB] FAIL rand_ctrl%0d: got %b want 1", i, last_ctrl_ok);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [17:0] a;
    logic [15:0] old_w, new_w;
    int          pulses;
    a = 18'h2A5A5; old_w = ref_get(a); new_w = ~old_w;
    req_we = 1'b1; req_addr = a; req_wdata = new_w; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    checks++; if (sram_we_n !== 1'b0) $display("[TB] FAIL mid_pulse_we: got %b want 0", sram_we_n); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1) $display("[TB] FAIL abort_we: got %b want 1", sram_we_n); else passes++;
    checks++; if (sram_ce_n !== 1'b1) $display("[TB] FAIL abort_ce: got %b want 1", sram_ce_n); else passes++;
    checks++; if (sram_dq !== 16'h0000) $display("[TB] FAIL abort_dq_released: got %h want 0000", sram_dq); else passes++;
    checks++; if (sram_addr !== 18'h0) $display("[TB] FAIL abort_addr: got %h want 00000", sram_addr); else passes++;
    checks++; if (rsp_rdata !== 16'h0) $display("[TB] FAIL abort_rdata: got %h want 0000", rsp_rdata); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) $display("[TB] FAIL abort_no_rsp: got %0d pulses want 0", pulses); else passes++;
    issue(1'b0, a, 16'h0, 2'b11);
    checks++;
    if (rsp_rdata !== old_w && rsp_rdata !== new_w)
      $display("[TB] FAIL abort_read: got %h want %h or %h", rsp_rdata, old_w, new_w);
    else begin
      passes++;
      ref_mem[a] = rsp_rdata;
    end
  endtask

  task automatic test_wait_params();
    int lat, oe_low, we_low;
    r2_we = 1'b0; r2_addr = 18'h00ABC; r2_be = 2'b11; r2_valid = 1'b1;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    lat = 1; oe_low = 0; we_low = 0;
    @(negedge clk);
    while (r2_rsp_valid !== 1'b1 && lat < 40) begin
      if (r2_oe_n === 1'b0) oe_low++;
      if (r2_we_n === 1'b0) we_low++;
      @(negedge clk);
      lat++;
    end
    checks++; if (oe_low !== 5) $display("[TB] FAIL p_rd_oe_low: got %0d want 5", oe_low); else passes++;
    checks++; if (we_low !== 0) $display("[TB] FAIL p_rd_we_low: got %0d want 0", we_low); else passes++;
    checks++; if (lat !== 6) $display("[TB] FAIL p_rd_latency: got %0d want 6", lat); else passes++;
    checks++; if (r2_rdata !== 16'h5A5A) $display("[TB] FAIL p_rd_data: got %h want 5a5a", r2_rdata); else passes++;
    r2_we = 1'b1; r2_wdata = 16'h1357; r2_valid = 1'b1;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    lat = 1; oe_low = 0; we_low = 0;
    @(negedge clk);
    while (r2_rsp_valid !== 1'b1 && lat < 40) begin
      if (r2_oe_n === 1'b0) oe_low++;
      if (r2_we_n === 1'b0) we_low++;
      @(negedge clk);
      lat++;
    end
    checks++; if (we_low !== 1) $display("[TB] FAIL p_wr_we_low: got %0d want 1", we_low); else passes++;
    checks++; if (oe_low !== 0) $display("[TB] FAIL p_wr_oe_low: got %0d want 0", oe_low); else passes++;
    checks++; if (lat !== 4) $display("[TB] FAIL p_wr_latency: got %0d want 4", lat); else passes++;
  endtask

  task automatic test_protocol();
    checks++; if (viol !== 0) $display("[TB] FAIL protocol_total: got %0d violations want 0", viol); else passes++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_byte_enables();
    test_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_wait_params();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
